multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
// Multi-cycle MIPS control unit; parametrised successor to the single-cycle decoder.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. Stalls on a memory ready handshake.
// Traps on illegal encodings and counts retired instructions.
// Sits between the instruction register (opcode/funct) and the shared multi-cycle datapath.
// PARAMETERS
// ALUOP_W    3   ALUop width; encodings in the low 3 bits, upper bits 0
// CNT_W      32  width of retired-instruction counter instret
// USE_READY  1   1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1
// PORTS
// clk          in   1        rising-edge clock
// rst_n        in   1        asynchronous active-low reset
// opcode       in   6        IR[31:26], stable from DECODE onward
// funct        in   6        IR[5:0]
// mem_ready    in   1        memory completes the current access this cycle
// PCWrite      out  1        unconditional PC load
// PCWriteCond  out  1        PC load if branch taken (datapath combines zero/BNE)
// IorD         out  1        0 = PC addresses memory, 1 = ALUOut addresses memory
// MemRead      out  1        memory read request
// MemWrite     out  1        memory write request
// IRWrite      out  1        load IR
// MemtoReg     out  1        write-back from MDR
// RegDst       out  1        rd (1) / rt (0) destination
// RegWrite     out  1        register file write
// ALUSrcA      out  1        0 = PC, 1 = rs
// ALUSrcB      out  2        00 rt, 01 const 4, 10 imm, 11 imm<<2
// PCSource     out  2        00 ALU, 01 ALUOut, 10 jump target, 11 rs (jr/jalr)
// ALUop        out  ALUOP_W  and 000, or 001, add 010, xor 011, nor 100, sll 101, sub 110, slt 111
// BNE, LUI, Jal, shift  out 1 each  as single-cycle decoder semantics
// signal       out  1        1 = zero-extend imm (andi/ori/xori)
// trap         out  1        sticky illegal-instruction flag
// state        out  4        current state, for debug
// instret      out  CNT_W    retired instruction count
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE(0), trap=0, instret=0, all control outputs 0.
// - IDLE->FETCH on first clock after reset release. IDLE outputs all 0.
// - States: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7,
//   R_WB 8, BRANCH 9, JUMP 10, I_EXEC 11, I_WB 12, JR 13, TRAP 14.
// - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=add, PCSource=00.
//   IRWrite=PCWrite=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
// - DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=add (branch target). Next state by opcode:
//   23/2b->MEM_ADDR; 00->R_EXEC (funct 08/09->JR); 04/05->BRANCH; 02/03->JUMP; 08,0a,0c,0d,0e,0f->I_EXEC.
//   Any other opcode, or an R-type funct outside {00,08,09,20,22,24,25,26,27,2a}, goes to TRAP.
// - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, add. Go to MEM_RD for lw, MEM_WR for sw.
// - MEM_RD: MemRead=1, IorD=1; hold until mem_ready; then MEM_WB.
// - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. MEM_WR: MemWrite=1, IorD=1; hold until mem_ready.
// - R_EXEC: ALUSrcA=1, ALUSrcB=00 (sll: shift=1, ALUSrcB=10); ALUop from funct. R_WB: RegWrite=1, RegDst=1.
// - I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUop addi add, slti slt, andi and, ori or, xori xor; signal=1 for 0c/0d/0e.
//   LUI=1 for 0f. I_WB: RegWrite=1, RegDst=0.
// - BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01, BNE=(opcode==05).
// - JUMP: PCWrite=1, PCSource=10; jal adds Jal=1, RegWrite=1 (writes $31).
// - JR: PCWrite=1, PCSource=11; jalr adds RegWrite=1, RegDst=1, Jal=1.
// - Retire cycles: MEM_WB, MEM_WR (with ready), R_WB, I_WB, BRANCH, JUMP, JR.
//   On a retire cycle, go to FETCH and instret+=1, wrapping modulo 2^CNT_W.
// - TRAP: trap=1, all other controls 0, absorbing until reset; instret frozen.
// - USE_READY=0: every memory state lasts exactly 1 cycle.
// - rst_n asserted mid-instruction aborts it immediately; no partial write strobes after the reset edge.
// TESTING
// - Reset release, mem_ready=1, add (op 00/fn 20): states 1,2,7,8,1; RegWrite only in R_WB; instret=1.
// - lw with mem_ready low 3 cycles in MEM_RD: MEM_RD held 4 cycles, MemRead=IorD=1 throughout; MEM_WB once.
// - bne (op 05): BRANCH with PCWriteCond=1, BNE=1, ALUop=110; 3 cycles total.
// - jal (op 03) then jalr (fn 09): Jal=1, RegWrite=1 in JUMP/JR; PCSource 10 then 11.
// - op 3f: DECODE->TRAP, trap=1 sticky, instret unchanged; rst_n low clears to IDLE.
// - CNT_W=4: retire 17 instructions -> instret=1; sw with rst_n pulse in MEM_WR -> no MemWrite after reset.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready,
// traps on illegal encodings and counts retired instructions.
module multicycle_control #(
    parameter int ALUOP_W   = 3,
    parameter int CNT_W     = 32,
    parameter bit USE_READY = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               BNE,
    output logic               LUI,
    output logic               Jal,
    output logic               shift,
    output logic               signal,
    output logic               trap,
    output logic [3:0]         state,
    output logic [CNT_W-1:0]   instret
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_I_EXEC   = 4'd11,
        S_I_WB     = 4'd12,
        S_JR       = 4'd13,
        S_TRAP     = 4'd14
    } state_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             rdy;
    logic             retire;
    logic             r_legal;
    logic             is_jr;
    logic [2:0]       r_alu;
    logic [2:0]       i_alu;
    logic [2:0]       alu3;

    // With the handshake disabled every memory access completes in one cycle.
    assign rdy = mem_ready | ~USE_READY;

    assign is_jr = (funct == 6'h08) || (funct == 6'h09);

    always_comb begin
        r_legal = 1'b1;
        r_alu   = ALU_ADD;
        case (funct)
            6'h00:   r_alu = ALU_SLL;
            6'h20:   r_alu = ALU_ADD;
            6'h22:   r_alu = ALU_SUB;
            6'h24:   r_alu = ALU_AND;
            6'h25:   r_alu = ALU_OR;
            6'h26:   r_alu = ALU_XOR;
            6'h27:   r_alu = ALU_NOR;
            6'h2a:   r_alu = ALU_SLT;
            6'h08,
            6'h09:   r_alu = ALU_ADD;
            default: r_legal = 1'b0;
        endcase
    end

    always_comb begin
        i_alu = ALU_ADD;
        case (opcode)
            6'h0a:   i_alu = ALU_SLT;
            6'h0c:   i_alu = ALU_AND;
            6'h0d:   i_alu = ALU_OR;
            6'h0e:   i_alu = ALU_XOR;
            default: i_alu = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'h23, 6'h2b: state_d = S_MEM_ADDR;
                    6'h00: begin
                        if (is_jr)        state_d = S_JR;
                        else if (r_legal) state_d = S_R_EXEC;
                        else              state_d = S_TRAP;
                    end
                    6'h04, 6'h05: state_d = S_BRANCH;
                    6'h02, 6'h03: state_d = S_JUMP;
                    6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f: state_d = S_I_EXEC;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == 6'h2b) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (rdy) state_d = S_MEM_WB;
            S_MEM_WR:   if (rdy) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR: retire = 1'b1;
            S_MEM_WR: retire = rdy;
            default:  retire = 1'b0;
        endcase
        instret_d = instret_q + CNT_W'(retire);
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        alu3        = ALU_AND;
        BNE         = 1'b0;
        LUI         = 1'b0;
        Jal         = 1'b0;
        shift       = 1'b0;
        signal      = 1'b0;
        trap        = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                alu3    = ALU_ADD;
                IRWrite = rdy;
                PCWrite = rdy;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                alu3    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu3    = ALU_ADD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                alu3    = r_alu;
                // sll takes its shift amount through the immediate path
                if (funct == 6'h00) begin
                    shift   = 1'b1;
                    ALUSrcB = 2'b10;
                end
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                alu3        = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BNE         = (opcode == 6'h05);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                Jal      = (opcode == 6'h03);
                RegWrite = (opcode == 6'h03);
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu3    = i_alu;
                signal  = (opcode == 6'h0c) || (opcode == 6'h0d) || (opcode == 6'h0e);
                LUI     = (opcode == 6'h0f);
            end
            S_I_WB:   RegWrite = 1'b1;
            S_JR: begin
                PCWrite  = 1'b1;
                PCSource = 2'b11;
                RegWrite = (funct == 6'h09);
                RegDst   = (funct == 6'h09);
                Jal      = (funct == 6'h09);
            end
            S_TRAP:   trap = 1'b1;
            default: ;
        endcase
        ALUop      = '0;
        ALUop[2:0] = alu3;
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected traces built from the instruction
// semantics, compared cycle by cycle against a ready-stalling and a ready-ignoring instance.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, pcs;
        logic [2:0] alu;
        logic       bne, lui, jal, sh, sg, trp;
    } ctrl_t;

    typedef struct {
        logic       rdy;
        logic [5:0] op, fn;
        logic [3:0] st;
        ctrl_t      c;
        bit         ret;
    } step_t;

    typedef struct {
        logic [3:0] st;
        ctrl_t      c;
        logic [3:0] cnt;
        logic [3:0] nst;
        ctrl_t      nc;
        logic [1:0] nhi;
        logic [7:0] ncnt;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       mem_ready = 1'b0;

    logic d_PCWrite, d_PCWriteCond, d_IorD, d_MemRead, d_MemWrite, d_IRWrite, d_MemtoReg;
    logic d_RegDst, d_RegWrite, d_ALUSrcA, d_BNE, d_LUI, d_Jal, d_shift, d_signal, d_trap;
    logic [1:0] d_ALUSrcB, d_PCSource;
    logic [2:0] d_ALUop;
    logic [3:0] d_state;
    logic [3:0] d_instret;

    logic n_PCWrite, n_PCWriteCond, n_IorD, n_MemRead, n_MemWrite, n_IRWrite, n_MemtoReg;
    logic n_RegDst, n_RegWrite, n_ALUSrcA, n_BNE, n_LUI, n_Jal, n_shift, n_signal, n_trap;
    logic [1:0] n_ALUSrcB, n_PCSource;
    logic [4:0] n_ALUop;
    logic [3:0] n_state;
    logic [7:0] n_instret;

    ctrl_t d_c, n_c;
    assign d_c = {d_PCWrite, d_PCWriteCond, d_IorD, d_MemRead, d_MemWrite, d_IRWrite, d_MemtoReg,
                  d_RegDst, d_RegWrite, d_ALUSrcA, d_ALUSrcB, d_PCSource, d_ALUop,
                  d_BNE, d_LUI, d_Jal, d_shift, d_signal, d_trap};
    assign n_c = {n_PCWrite, n_PCWriteCond, n_IorD, n_MemRead, n_MemWrite, n_IRWrite, n_MemtoReg,
                  n_RegDst, n_RegWrite, n_ALUSrcA, n_ALUSrcB, n_PCSource, n_ALUop[2:0],
                  n_BNE, n_LUI, n_Jal, n_shift, n_signal, n_trap};

    multicycle_control #(.ALUOP_W(3), .CNT_W(4), .USE_READY(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(d_PCWrite), .PCWriteCond(d_PCWriteCond), .IorD(d_IorD), .MemRead(d_MemRead),
        .MemWrite(d_MemWrite), .IRWrite(d_IRWrite), .MemtoReg(d_MemtoReg), .RegDst(d_RegDst),
        .RegWrite(d_RegWrite), .ALUSrcA(d_ALUSrcA), .ALUSrcB(d_ALUSrcB), .PCSource(d_PCSource),
        .ALUop(d_ALUop), .BNE(d_BNE), .LUI(d_LUI), .Jal(d_Jal), .shift(d_shift),
        .signal(d_signal), .trap(d_trap), .state(d_state), .instret(d_instret)
    );

    multicycle_control #(.ALUOP_W(5), .CNT_W(8), .USE_READY(1'b0)) u_nr (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(n_PCWrite), .PCWriteCond(n_PCWriteCond), .IorD(n_IorD), .MemRead(n_MemRead),
        .MemWrite(n_MemWrite), .IRWrite(n_IRWrite), .MemtoReg(n_MemtoReg), .RegDst(n_RegDst),
        .RegWrite(n_RegWrite), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .PCSource(n_PCSource),
        .ALUop(n_ALUop), .BNE(n_BNE), .LUI(n_LUI), .Jal(n_Jal), .shift(n_shift),
        .signal(n_signal), .trap(n_trap), .state(n_state), .instret(n_instret)
    );

    int    checks = 0;
    int    errors = 0;
    int    m_cnt  = 0;
    step_t exp_q[$];
    obs_t  obs_q[$];

    localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_XOR = 3'b011;
    localparam logic [2:0] A_NOR = 3'b100, A_SLL = 3'b101, A_SUB = 3'b110, A_SLT = 3'b111;

    logic [11:0] legal_tab [22] = '{
        {6'h23, 6'h00}, {6'h2b, 6'h00}, {6'h00, 6'h00}, {6'h00, 6'h20}, {6'h00, 6'h22},
        {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h26}, {6'h00, 6'h27}, {6'h00, 6'h2a},
        {6'h00, 6'h08}, {6'h00, 6'h09}, {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h02, 6'h00},
        {6'h03, 6'h00}, {6'h08, 6'h00}, {6'h0a, 6'h00}, {6'h0c, 6'h00}, {6'h0d, 6'h00},
        {6'h0e, 6'h00}, {6'h0f, 6'h00}
    };

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic ctrl_t fetch_c(input logic r);
        ctrl_t c;
        c     = '0;
        c.mrd = 1'b1;
        c.asb = 2'b01;
        c.alu = A_ADD;
        c.irw = r;
        c.pcw = r;
        return c;
    endfunction

    function automatic void push(input logic r, input logic [5:0] op, input logic [5:0] fn,
                                 input logic [3:0] st, input ctrl_t c, input bit ret);
        step_t s;
        s.rdy = r; s.op = op; s.fn = fn; s.st = st; s.c = c; s.ret = ret;
        exp_q.push_back(s);
    endfunction

    // ALU operation an R-type funct asks for; -1 marks an illegal funct.
    function automatic int r_code(input logic [5:0] fn);
        case (fn)
            6'h20: return int'(A_ADD);
            6'h22: return int'(A_SUB);
            6'h24: return int'(A_AND);
            6'h25: return int'(A_OR);
            6'h26: return int'(A_XOR);
            6'h27: return int'(A_NOR);
            6'h2a: return int'(A_SLT);
            6'h00: return int'(A_SLL);
            default: return -1;
        endcase
    endfunction

    function automatic void add_instr(input logic [5:0] op, input logic [5:0] fn,
                                      input int fstall, input int mstall);
        ctrl_t      c;
        logic [3:0] st;
        bit         trapped;
        trapped = 1'b0;
        for (int i = 0; i < fstall; i++) push(1'b0, op, fn, 4'd1, fetch_c(1'b0), 1'b0);
        push(1'b1, op, fn, 4'd1, fetch_c(1'b1), 1'b0);
        c = '0; c.asb = 2'b11; c.alu = A_ADD;
        push(rb(), op, fn, 4'd2, c, 1'b0);
        case (op)
            6'h23, 6'h2b: begin
                c = '0; c.asa = 1'b1; c.asb = 2'b10; c.alu = A_ADD;
                push(rb(), op, fn, 4'd3, c, 1'b0);
                c = '0; c.iord = 1'b1;
                if (op == 6'h23) begin c.mrd = 1'b1; st = 4'd4; end
                else begin c.mwr = 1'b1; st = 4'd6; end
                for (int i = 0; i < mstall; i++) push(1'b0, op, fn, st, c, 1'b0);
                push(1'b1, op, fn, st, c, op == 6'h2b);
                if (op == 6'h23) begin
                    c = '0; c.rw = 1'b1; c.m2r = 1'b1;
                    push(rb(), op, fn, 4'd5, c, 1'b1);
                end
            end
            6'h00: begin
                if (fn == 6'h08 || fn == 6'h09) begin
                    c = '0; c.pcw = 1'b1; c.pcs = 2'b11;
                    if (fn == 6'h09) begin c.rw = 1'b1; c.rdst = 1'b1; c.jal = 1'b1; end
                    push(rb(), op, fn, 4'd13, c, 1'b1);
                end else if (r_code(fn) >= 0) begin
                    c = '0; c.asa = 1'b1; c.alu = 3'(r_code(fn));
                    if (fn == 6'h00) begin c.sh = 1'b1; c.asb = 2'b10; end
                    push(rb(), op, fn, 4'd7, c, 1'b0);
                    c = '0; c.rw = 1'b1; c.rdst = 1'b1;
                    push(rb(), op, fn, 4'd8, c, 1'b1);
                end else trapped = 1'b1;
            end
            6'h04, 6'h05: begin
                c = '0; c.asa = 1'b1; c.alu = A_SUB; c.pcwc = 1'b1; c.pcs = 2'b01;
                c.bne = (op == 6'h05);
                push(rb(), op, fn, 4'd9, c, 1'b1);
            end
            6'h02, 6'h03: begin
                c = '0; c.pcw = 1'b1; c.pcs = 2'b10;
                if (op == 6'h03) begin c.jal = 1'b1; c.rw = 1'b1; end
                push(rb(), op, fn, 4'd10, c, 1'b1);
            end
            6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
                c = '0; c.asa = 1'b1; c.asb = 2'b10;
                case (op)
                    6'h0a:   c.alu = A_SLT;
                    6'h0c:   begin c.alu = A_AND; c.sg = 1'b1; end
                    6'h0d:   begin c.alu = A_OR;  c.sg = 1'b1; end
                    6'h0e:   begin c.alu = A_XOR; c.sg = 1'b1; end
                    6'h0f:   begin c.alu = A_ADD; c.lui = 1'b1; end
                    default: c.alu = A_ADD;
                endcase
                push(rb(), op, fn, 4'd11, c, 1'b0);
                c = '0; c.rw = 1'b1;
                push(rb(), op, fn, 4'd12, c, 1'b1);
            end
            default: trapped = 1'b1;
        endcase
        if (trapped) begin
            c = '0; c.trp = 1'b1;
            for (int i = 0; i < 4; i++) push(rb(), op, fn, 4'd14, c, 1'b0);
        end
    endfunction

    function automatic void add_random(input int fmax, input int mmax);
        logic [11:0] e;
        logic [5:0]  fn;
        e  = legal_tab[$urandom_range(0, 21)];
        fn = (e[11:6] == 6'h00) ? e[5:0] : 6'($urandom);
        add_instr(e[11:6], fn, int'($urandom_range(0, fmax)), int'($urandom_range(0, mmax)));
    endfunction

    task automatic play(input bit force_rdy0);
        obs_t o;
        obs_q.delete();
        foreach (exp_q[i]) begin
            opcode    = exp_q[i].op;
            funct     = exp_q[i].fn;
            mem_ready = force_rdy0 ? 1'b0 : exp_q[i].rdy;
            @(negedge clk);
            o.st = d_state; o.c = d_c; o.cnt = d_instret;
            o.nst = n_state; o.nc = n_c; o.nhi = n_ALUop[4:3]; o.ncnt = n_instret;
            obs_q.push_back(o);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h23;
        #1;
        checks++; if (d_state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", d_state); end
        checks++; if (d_c !== ctrl_t'(0)) begin errors++; $display("FAIL reset_ctrl got %h want 0", d_c); end
        checks++; if (d_instret !== 4'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", d_instret); end
        checks++; if (n_c !== ctrl_t'(0) || n_ALUop !== 5'd0 || n_instret !== 8'd0) begin
            errors++; $display("FAIL reset_nr got %h/%h/%0d want 0", n_c, n_ALUop, n_instret); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (d_state !== 4'd0 || d_c !== ctrl_t'(0)) begin
            errors++; $display("FAIL idle_after_release got %0d/%h want 0/0", d_state, d_c); end
        @(posedge clk); #1;
        checks++; if (d_state !== 4'd1) begin errors++; $display("FAIL first_fetch got %0d want 1", d_state); end
    endtask

    task automatic test_directed();
        do_reset();
        exp_q.delete();
        add_instr(6'h00, 6'h20, 0, 0);
        add_instr(6'h23, 6'h00, 0, 3);
        add_instr(6'h05, 6'h00, 0, 0);
        add_instr(6'h03, 6'h00, 0, 0);
        add_instr(6'h00, 6'h09, 0, 0);
        add_instr(6'h00, 6'h00, 2, 0);
        add_instr(6'h0f, 6'h11, 0, 0);
        add_instr(6'h2b, 6'h00, 1, 2);
        play(1'b0);
        foreach (obs_q[i]) begin
            checks++; if (obs_q[i].st !== exp_q[i].st) begin errors++;
                $display("FAIL directed[%0d] state got %0d want %0d", i, obs_q[i].st, exp_q[i].st); end
            checks++; if (obs_q[i].c !== exp_q[i].c) begin errors++;
                $display("FAIL directed[%0d] ctrl got %h want %h", i, obs_q[i].c, exp_q[i].c); end
            checks++; if (obs_q[i].cnt !== 4'(m_cnt)) begin errors++;
                $display("FAIL directed[%0d] instret got %0d want %0d", i, obs_q[i].cnt, 4'(m_cnt)); end
            if (exp_q[i].ret) m_cnt++;
        end
    endtask

    task automatic test_random();
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 40; k++) add_random(2, 3);
        play(1'b0);
        foreach (obs_q[i]) begin
            checks++; if (obs_q[i].st !== exp_q[i].st || obs_q[i].c !== exp_q[i].c) begin errors++;
                $display("FAIL random[%0d] op %h fn %h state/ctrl got %0d/%h want %0d/%h", i, exp_q[i].op,
                         exp_q[i].fn, obs_q[i].st, obs_q[i].c, exp_q[i].st, exp_q[i].c); end
            checks++; if (obs_q[i].cnt !== 4'(m_cnt)) begin errors++;
                $display("FAIL random[%0d] instret got %0d want %0d", i, obs_q[i].cnt, 4'(m_cnt)); end
            if (exp_q[i].ret) m_cnt++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 17; k++) add_random(0, 0);
        play(1'b0);
        foreach (obs_q[i]) begin
            checks++; if (obs_q[i].st !== exp_q[i].st || obs_q[i].cnt !== 4'(m_cnt)) begin errors++;
                $display("FAIL wrap[%0d] state/instret got %0d/%0d want %0d/%0d", i, obs_q[i].st,
                         obs_q[i].cnt, exp_q[i].st, 4'(m_cnt)); end
            if (exp_q[i].ret) m_cnt++;
        end
        checks++; if (d_instret !== 4'd1) begin errors++; $display("FAIL wrap_final instret got %0d want 1", d_instret); end
    endtask

    task automatic test_trap();
        do_reset();
        exp_q.delete();
        add_instr(6'h00, 6'h20, 0, 0);
        add_instr(6'h3f, 6'h00, 0, 0);
        play(1'b0);
        foreach (obs_q[i]) begin
            checks++; if (obs_q[i].st !== exp_q[i].st || obs_q[i].c !== exp_q[i].c) begin errors++;
                $display("FAIL trap_op[%0d] state/ctrl got %0d/%h want %0d/%h", i, obs_q[i].st, obs_q[i].c,
                         exp_q[i].st, exp_q[i].c); end
            checks++; if (obs_q[i].cnt !== 4'(m_cnt)) begin errors++;
                $display("FAIL trap_op[%0d] instret got %0d want %0d", i, obs_q[i].cnt, 4'(m_cnt)); end
            if (exp_q[i].ret) m_cnt++;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (d_state !== 4'd0 || d_trap !== 1'b0 || d_instret !== 4'd0) begin errors++;
            $display("FAIL trap_clear got %0d/%b/%0d want 0/0/0", d_state, d_trap, d_instret); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_cnt = 0;
        exp_q.delete();
        add_instr(6'h00, 6'h01, 0, 0);
        play(1'b0);
        foreach (obs_q[i]) begin
            checks++; if (obs_q[i].st !== exp_q[i].st || obs_q[i].c !== exp_q[i].c || obs_q[i].cnt !== 4'd0) begin
                errors++; $display("FAIL trap_fn[%0d] state/ctrl/instret got %0d/%h/%0d want %0d/%h/0", i,
                         obs_q[i].st, obs_q[i].c, obs_q[i].cnt, exp_q[i].st, exp_q[i].c); end
        end
    endtask

    task automatic test_sw_reset();
        do_reset();
        exp_q.delete();
        add_instr(6'h2b, 6'h00, 0, 5);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        play(1'b0);
        checks++; if (d_state !== 4'd6 || d_MemWrite !== 1'b1) begin errors++;
            $display("FAIL sw_pre state/MemWrite got %0d/%b want 6/1", d_state, d_MemWrite); end
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        checks++; if (d_MemWrite !== 1'b0 || d_state !== 4'd0) begin errors++;
            $display("FAIL sw_abort state/MemWrite got %0d/%b want 0/0", d_state, d_MemWrite); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (d_MemWrite !== 1'b0 || d_instret !== 4'd0) begin errors++;
                $display("FAIL sw_hold[%0d] MemWrite/instret got %b/%0d want 0/0", k, d_MemWrite, d_instret); end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_no_ready();
        int cnt;
        do_reset();
        cnt = 0;
        exp_q.delete();
        add_instr(6'h23, 6'h00, 0, 0);
        add_instr(6'h2b, 6'h00, 0, 0);
        add_instr(6'h00, 6'h27, 0, 0);
        add_instr(6'h0e, 6'h00, 0, 0);
        play(1'b1);
        foreach (obs_q[i]) begin
            checks++; if (obs_q[i].nst !== exp_q[i].st || obs_q[i].nc !== exp_q[i].c || obs_q[i].nhi !== 2'b00) begin
                errors++; $display("FAIL noready[%0d] state/ctrl/hi got %0d/%h/%b want %0d/%h/00", i,
                         obs_q[i].nst, obs_q[i].nc, obs_q[i].nhi, exp_q[i].st, exp_q[i].c); end
            checks++; if (obs_q[i].ncnt !== 8'(cnt)) begin errors++;
                $display("FAIL noready[%0d] instret got %0d want %0d", i, obs_q[i].ncnt, 8'(cnt)); end
            checks++; if (obs_q[i].st !== 4'd1 || obs_q[i].c.irw !== 1'b0) begin errors++;
                $display("FAIL stall_fetch[%0d] state/IRWrite got %0d/%b want 1/0", i, obs_q[i].st, obs_q[i].c.irw); end
            if (exp_q[i].ret) cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_wrap();
        test_trap();
        test_sw_reset();
        test_no_ready();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
